alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: NUM_OPS, 2, number of legal opcodes (0..NUM_OPS-1); opcode 0 = add, 1 = sub.
REQ-002 The port list SHALL be as follows:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  byte-serial command/operand stream.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- alu_opcode  out  4  opcode to the downstream ALU, registered.
- alu_a  out  8  operand A to the ALU, registered.
- alu_b  out  8  operand B to the ALU, registered.
- alu_result  in  8  combinational ALU result.
- out_data  out  8  captured result.
- out_err  out  1  result belongs to an illegal-opcode frame.
- out_valid  out  1  out_data/out_err valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than CMD.

Function
REQ-003 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1; out_data SHALL transfer only on a cycle with out_valid=1 and out_ready=1.
REQ-004 The command byte format SHALL be: [7:4] opcode; [3] use_acc; [2:0] reserved and ignored.
REQ-005 The FSM SHALL have the states CMD, GET_A, GET_B, EXEC and RESULT; its reset state SHALL be CMD.
REQ-006 in_ready SHALL be 1 in CMD, GET_A and GET_B, and 0 in EXEC and RESULT.
REQ-007 CMD: on transfer, opcode and use_acc SHALL be latched; next state GET_B if use_acc=1, else GET_A.
REQ-008 GET_A: on transfer, in_data SHALL be loaded into alu_a; next state GET_B.
REQ-009 GET_B: on transfer, in_data SHALL be loaded into alu_b, alu_opcode SHALL be loaded with the latched opcode, and alu_a SHALL be loaded with acc if use_acc=1; next state EXEC.
REQ-010 Absent a transfer, CMD, GET_A and GET_B SHALL hold state and all registers.
REQ-011 EXEC SHALL last exactly one cycle and then go to RESULT.
- Legal opcode (< NUM_OPS): out_data <= alu_result, out_err <= 0, acc <= alu_result.
- Illegal opcode: out_data <= 0x00, out_err <= 1, acc unchanged.
REQ-012 RESULT: out_valid SHALL be 1; out_data and out_err SHALL hold stable until transfer; on transfer next state CMD with out_valid=0.
REQ-013 Latency: if the last byte transfers in cycle N, out_valid SHALL rise in cycle N+2; the next command byte is acceptable in the cycle after the result transfer.
REQ-014 Arithmetic is performed by the ALU; results SHALL be treated as 8-bit modulo 256 (sub wraps, e.g. 0x05-0x07 = 0xFE).
REQ-015 acc SHALL be an 8-bit internal register, not visible at the ports.
REQ-016 alu_opcode, alu_a and alu_b SHALL change only in GET_A/GET_B transfer cycles and on reset; they SHALL remain stable through EXEC.
REQ-017 in_valid asserted in EXEC or RESULT SHALL NOT consume a byte; the producer holds it.
REQ-018 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-019 With rst=1 at a clock edge, the block SHALL go to CMD with: in_ready=1 in the next cycle; out_valid=0, out_err=0, busy=0; out_data, alu_opcode, alu_a, alu_b and acc all 0.
REQ-020 Reset SHALL take priority over every transfer in the same cycle, and any partial frame SHALL be discarded.

Verification
REQ-021 Add: bytes 0x00,0x12,0x34 with out_ready=1 -> out_data=0x46, out_err=0, out_valid exactly 2 cycles after the 0x34 transfer.
REQ-022 Sub wrap: 0x10,0x05,0x07 -> out_data=0xFE, out_err=0.
REQ-023 Accumulator: after REQ-021, send 0x08,0x01 -> two-byte frame, alu_a=0x46, out_data=0x47.
REQ-024 Illegal opcode: 0x30,0xAA,0xBB -> out_data=0x00, out_err=1; a following 0x08,0x00 frame returns the prior acc value.
REQ-025 Backpressure and reset:
- Hold out_ready=0 for 5 cycles in RESULT -> out_valid, out_data and out_err stable, in_ready=0; after the transfer, in_ready=1 the next cycle.
- rst pulse after an A byte -> a following 0x00,0x01,0x02 frame yields 0x03.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Byte-serial command sequencer for an external combinational
//               ALU. It collects a command byte and one or two operand bytes,
//               presents the registered operands to the ALU and captures the
//               result into an output holding register with a valid/ready
//               handshake. An internal accumulator keeps the last legal
//               result so that a frame can reuse it as operand A.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_data/in_valid/in_ready   - command/operand byte stream
//               alu_opcode/alu_a/alu_b      - registered ALU inputs
//               alu_result                  - combinational ALU result
//               out_data/out_err/out_valid/out_ready - result stream
//               busy                - high whenever not waiting for a command
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int NUM_OPS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] out_data,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t      state_q;
    logic [3:0]  cmd_op_q;       // opcode latched from the command byte
    logic        use_acc_q;      // frame takes operand A from the accumulator
    logic [7:0]  acc_q;
    logic [3:0]  alu_opcode_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [7:0]  out_data_q;
    logic        out_err_q;
    logic        out_valid_q;

    logic        in_xfer;
    logic        op_legal;

    // Command byte bits [2:0] are reserved and deliberately ignored.
    logic        unused_in_bits;
    assign unused_in_bits = &{1'b0, in_data[2:0]};

    // in_ready/busy are pure decodes of the state register.
    assign in_ready = (state_q == S_CMD) || (state_q == S_GET_A) || (state_q == S_GET_B);
    assign busy     = (state_q != S_CMD);
    assign in_xfer  = in_valid && in_ready;

    // Legality is judged on the opcode already presented to the ALU, which
    // is the opcode the result in EXEC belongs to.
    assign op_legal = ({28'd0, alu_opcode_q} < 32'(NUM_OPS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CMD;
            cmd_op_q     <= 4'd0;
            use_acc_q    <= 1'b0;
            acc_q        <= 8'd0;
            alu_opcode_q <= 4'd0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            out_data_q   <= 8'd0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (in_xfer) begin
                        cmd_op_q  <= in_data[7:4];
                        use_acc_q <= in_data[3];
                        state_q   <= in_data[3] ? S_GET_B : S_GET_A;
                    end
                end
                S_GET_A: begin
                    if (in_xfer) begin
                        alu_a_q <= in_data;
                        state_q <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (in_xfer) begin
                        alu_b_q      <= in_data;
                        alu_opcode_q <= cmd_op_q;
                        if (use_acc_q) begin
                            alu_a_q <= acc_q;
                        end
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for this whole cycle.
                    if (op_legal) begin
                        out_data_q <= alu_result;
                        out_err_q  <= 1'b0;
                        acc_q      <= alu_result;
                    end else begin
                        out_data_q <= 8'd0;
                        out_err_q  <= 1'b1;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_RESULT;
                end
                S_RESULT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_CMD;
                    end
                end
                default: begin
                    state_q     <= S_CMD;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. Provides an
//               add/sub ALU model, a table of command frames with expected
//               results, and directed sequences for backpressure and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_sequencer #(.NUM_OPS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Downstream ALU: add, sub, and a junk value for any other opcode so an
    // illegal opcode that leaked through would be visible.
    always_comb begin
        alu_result = 8'hEE;
        if (alu_opcode == 4'd0) alu_result = alu_a + alu_b;
        else if (alu_opcode == 4'd1) alu_result = alu_a - alu_b;
    end

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        logic [7:0] exp_a;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) check("in_ready_timeout", {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the last byte's transfer edge (cycle N+1).
    task automatic finish_frame(input logic [7:0] exp_data, input logic exp_err,
                                input logic [7:0] exp_a);
        int w;
        w = 0;
        check("exec_out_valid", {7'd0, out_valid}, 8'd0);
        check("exec_in_ready", {7'd0, in_ready}, 8'd0);
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        check("latency", 8'(w + 1), 8'd2);
        check("out_data", out_data, exp_data);
        check("out_err", {7'd0, out_err}, {7'd0, exp_err});
        check("alu_a", alu_a, exp_a);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", {7'd0, out_valid}, 8'd0);
        check("post_in_ready", {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        logic [7:0] hold_data;
        vecs[0] = '{8'h00, 8'h12, 8'h34, 3, 8'h12, 8'h46, 1'b0};
        vecs[1] = '{8'h08, 8'h01, 8'h00, 2, 8'h46, 8'h47, 1'b0};
        vecs[2] = '{8'h30, 8'hAA, 8'hBB, 3, 8'hAA, 8'h00, 1'b1};
        vecs[3] = '{8'h08, 8'h00, 8'h00, 2, 8'h47, 8'h47, 1'b0};
        vecs[4] = '{8'h10, 8'h05, 8'h07, 3, 8'h05, 8'hFE, 1'b0};
        vecs[5] = '{8'h18, 8'h03, 8'h00, 2, 8'hFE, 8'hFB, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 8'h02, 3, 8'hFF, 8'h01, 1'b0};
        vecs[7] = '{8'h07, 8'h01, 8'h02, 3, 8'h01, 8'h03, 1'b0};
        vecs[8] = '{8'h1F, 8'h01, 8'h00, 2, 8'h03, 8'h02, 1'b0};

        rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_out_err", {7'd0, out_err}, 8'd0);
        check("rst_out_data", out_data, 8'd0);
        check("rst_alu_a", alu_a, 8'd0);
        check("rst_alu_b", alu_b, 8'd0);
        check("rst_alu_opcode", {4'd0, alu_opcode}, 8'd0);

        // Table-driven frames (accumulator carries between entries)
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            if (vecs[i].n == 3) send_byte(vecs[i].b2);
            finish_frame(vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_a);
        end

        // Idle in GET_A holds registers
        send_byte(8'h00);
        hold_data = alu_a;
        for (int k = 0; k < 3; k++) tick();
        check("hold_busy", {7'd0, busy}, 8'd1);
        check("hold_alu_a", alu_a, hold_data);
        send_byte(8'h01);
        send_byte(8'h01);
        // Backpressure: result held for 5 cycles while a command byte waits
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        in_data  = 8'h00;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_out_valid", {7'd0, out_valid}, 8'd1);
            check("bp_out_data", out_data, 8'h02);
            check("bp_out_err", {7'd0, out_err}, 8'd0);
            check("bp_in_ready", {7'd0, in_ready}, 8'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", {7'd0, out_valid}, 8'd0);
        check("bp_release_in_ready", {7'd0, in_ready}, 8'd1);
        tick();                       // held command byte is consumed now
        in_valid = 1'b0;
        check("bp_cmd_taken_busy", {7'd0, busy}, 8'd1);
        send_byte(8'h04);
        send_byte(8'h05);
        finish_frame(8'h09, 1'b0, 8'h04);

        // Reset after an A byte discards the frame and clears acc
        send_byte(8'h00);
        send_byte(8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("mid_rst_alu_a", alu_a, 8'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        finish_frame(8'h03, 1'b0, 8'h01);

        // Reset wins over a GET_B transfer in the same cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_byte(8'h08);
        send_byte(8'h05);
        finish_frame(8'h05, 1'b0, 8'h00);
        send_byte(8'h00);
        send_byte(8'h11);
        in_data  = 8'h22;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_busy", {7'd0, busy}, 8'd0);
        check("rst_prio_alu_b", alu_b, 8'd0);
        tick();
        check("rst_prio_out_valid", {7'd0, out_valid}, 8'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        finish_frame(8'h03, 1'b0, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
